// File: rtl/remote_filter_pkg.sv
// ============================================================================
// remote_filter_pkg
// Shared frame constants and loader state encoding for the remote FIR path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package remote_filter_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_ENABLE = 8'h02;
  localparam logic [7:0] CMD_BYPASS = 8'h03;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gap_timer.sv
// ============================================================================
// gap_timer
// Counts idle cycles while run is high and flags expiry at TIMEOUT_CYCLES.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

  logic [c_cnt_w-1:0] r_count;

  // Saturates at the limit so a stalled supervisor keeps reporting expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != c_limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = run && !clear && (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/remote_coeff_loader.sv
// ============================================================================
// remote_coeff_loader
// Parses SYNC/CMD/PAYLOAD/CHK byte frames into FIR coefficients and enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module remote_coeff_loader
  import remote_filter_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TAPS = 7,
  parameter int unsigned COEFF_BITS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [7:0]                           rx_data,
  input  logic                                 rx_valid,
  output logic                                 rx_ready,
  output logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] coeffs,
  output logic                                 filter_en,
  output logic                                 coeff_update,
  output logic                                 frame_err,
  output logic                                 busy
);

  localparam int unsigned c_payload_bytes = NUMBER_OF_TAPS * COEFF_BITS / 8;
  localparam int unsigned c_cnt_w         = $clog2(c_payload_bytes + 1);
  localparam int unsigned c_vec_w         = NUMBER_OF_TAPS * COEFF_BITS;
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_payload_bytes - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_cmd;
  logic [7:0]           r_xor;
  logic [c_cnt_w-1:0]   r_byte_cnt;
  logic [c_vec_w-1:0]   r_shadow;
  logic [c_vec_w-1:0]   r_coeffs;
  logic                 r_filter_en;
  logic                 r_coeff_update;
  logic                 r_frame_err;

  logic                 w_accept;
  logic                 w_timer_run;
  logic                 w_timer_clear;
  logic                 w_expired;
  logic                 w_err;
  logic                 w_latch_cmd;
  logic                 w_store_byte;
  logic                 w_discard;
  logic                 w_commit;

  assign rx_ready     = (r_state != COMMIT);
  assign busy         = (r_state != IDLE);
  assign coeffs       = r_coeffs;
  assign filter_en    = r_filter_en;
  assign coeff_update = r_coeff_update;
  assign frame_err    = r_frame_err;

  assign w_accept      = rx_valid && rx_ready;
  assign w_timer_run   = (r_state == CMD) || (r_state == PAYLOAD) || (r_state == CHECK);
  assign w_timer_clear = w_accept || !w_timer_run;

  gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_timer_clear),
    .run     (w_timer_run),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_err        = 1'b0;
    w_latch_cmd  = 1'b0;
    w_store_byte = 1'b0;
    w_discard    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (rx_data == SYNC_BYTE)) begin
          w_next_state = CMD;
        end
      end
      CMD: begin
        if (w_expired) begin
          w_err        = 1'b1;
          w_discard    = 1'b1;
          w_next_state = IDLE;
        end else if (w_accept) begin
          case (rx_data)
            CMD_LOAD: begin
              w_latch_cmd  = 1'b1;
              w_next_state = PAYLOAD;
            end
            CMD_ENABLE, CMD_BYPASS: begin
              w_latch_cmd  = 1'b1;
              w_next_state = CHECK;
            end
            default: begin
              w_err        = 1'b1;
              w_next_state = IDLE;
            end
          endcase
        end
      end
      PAYLOAD: begin
        if (w_expired) begin
          w_err        = 1'b1;
          w_discard    = 1'b1;
          w_next_state = IDLE;
        end else if (w_accept) begin
          w_store_byte = 1'b1;
          if (r_byte_cnt == c_last_idx) begin
            w_next_state = CHECK;
          end
        end
      end
      CHECK: begin
        if (w_expired) begin
          w_err        = 1'b1;
          w_discard    = 1'b1;
          w_next_state = IDLE;
        end else if (w_accept) begin
          if (rx_data == r_xor) begin
            w_next_state = COMMIT;
          end else begin
            w_err        = 1'b1;
            w_discard    = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      COMMIT: begin
        w_commit     = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // The running XOR is seeded with CMD for every command so that payload-less
  // frames check against CHK == CMD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd          <= '0;
      r_xor          <= '0;
      r_byte_cnt     <= '0;
      r_shadow       <= '0;
      r_coeffs       <= '0;
      r_filter_en    <= 1'b0;
      r_coeff_update <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_coeff_update <= w_commit;
      r_frame_err    <= w_err;
      if (w_latch_cmd) begin
        r_cmd      <= rx_data;
        r_xor      <= rx_data;
        r_byte_cnt <= '0;
      end
      if (w_store_byte) begin
        for (int i = 0; i < c_payload_bytes; i++) begin
          if (r_byte_cnt == c_cnt_w'(i)) begin
            r_shadow[i*8 +: 8] <= rx_data;
          end
        end
        r_xor      <= r_xor ^ rx_data;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (w_discard) begin
        r_shadow <= '0;
      end
      if (w_commit) begin
        case (r_cmd)
          CMD_LOAD:   r_coeffs    <= r_shadow;
          CMD_ENABLE: r_filter_en <= 1'b1;
          CMD_BYPASS: r_filter_en <= 1'b0;
          default:    r_filter_en <= r_filter_en;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
